// File: rtl/axis_pkg.sv
// Shared AXI-Stream constants and helpers.
// Pointer sizing lives here so every block computes the same width.
package axis_pkg;

    localparam int AXIS_WIDTH_DEF = 8;

    // ceil(log2(n)); returns 0 for n <= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_fifo_if.sv
// AXI-Stream channel bundle: data, end-of-packet, and valid/ready handshake.
// The master drives tdata/tvalid/tlast; the slave drives tready.
interface axis_fifo_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: registered write, combinational read.
// The async read is what gives the FIFO its first-word fall-through.
module axis_fifo_ram #(
    parameter int DW      = 9,
    parameter int c_DEPTH = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_fifo.sv
// Single-clock AXI-Stream FIFO with first-word fall-through.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module axis_fifo
    import axis_pkg::*;
#(
    parameter  int c_WIDTH = AXIS_WIDTH_DEF,
    parameter  int c_DEPTH = 16,
    localparam int AW      = clog2(c_DEPTH),
    localparam int PW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    axis_fifo_if.slave    s_axis,
    axis_fifo_if.master   m_axis,
    output logic [PW-1:0] count
);
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic               full, empty, push, pop;
    logic [c_WIDTH:0]   rd_word;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;

    // Flags come from registered pointers only; rst masks them so nothing
    // handshakes while the pointers are being cleared.
    assign s_axis.tready = !full  && !rst;
    assign m_axis.tvalid = !empty && !rst;

    assign push = s_axis.tvalid && s_axis.tready;
    assign pop  = m_axis.tvalid && m_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Head slot is never written while occupied, so the output holds until popped.
    axis_fifo_ram #(
        .DW      (c_WIDTH + 1),
        .c_DEPTH (c_DEPTH),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({s_axis.tlast, s_axis.tdata}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    assign m_axis.tdata = rd_word[c_WIDTH-1:0];
    assign m_axis.tlast = rd_word[c_WIDTH];
endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo (8-bit, depth 4): vector table for the
// handshake/full/empty/reset cases plus a randomized-backpressure stream.
module tb_axis_fifo;
    logic       clk;
    logic       rst;
    logic [2:0] count;

    axis_fifo_if #(.W(8)) s_if ();
    axis_fifo_if #(.W(8)) m_if ();

    axis_fifo #(.c_WIDTH(8), .c_DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if),
        .m_axis (m_if),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       sv;
        logic [7:0] sd;
        logic       sl;
        logic       mr;
        logic       esr;
        logic       emv;
        logic [7:0] emd;
        logic       eml;
        logic [2:0] ecnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic sv, input logic [7:0] sd, input logic sl,
                       input logic mr, input logic esr, input logic emv,
                       input logic [7:0] emd, input logic eml, input logic [2:0] ecnt);
        vec_t v;
        v.r = r; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.esr = esr; v.emv = emv; v.emd = emd; v.eml = eml; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] lfsr;
    int          sent, rcvd, cyc;

    initial begin
        rst = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = 8'h00; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        repeat (2) step();

        //    r  sv sd     sl mr   esr emv emd    eml ecnt
        add(1, 0, 8'h00, 0, 0,   0,  0, 8'h00, 0, 3'd0);  // held in reset
        add(0, 1, 8'h11, 0, 0,   1,  0, 8'h00, 0, 3'd0);  // ready on first cycle
        add(0, 1, 8'h22, 0, 0,   1,  1, 8'h11, 0, 3'd1);
        add(0, 1, 8'h33, 1, 0,   1,  1, 8'h11, 0, 3'd2);
        add(0, 0, 8'h00, 0, 0,   1,  1, 8'h11, 0, 3'd3);
        add(0, 1, 8'h44, 0, 0,   1,  1, 8'h11, 0, 3'd3);
        add(0, 1, 8'h55, 0, 0,   0,  1, 8'h11, 0, 3'd4);  // full: 0x55 dropped
        add(0, 0, 8'h00, 0, 0,   0,  1, 8'h11, 0, 3'd4);
        add(0, 0, 8'h00, 0, 1,   0,  1, 8'h11, 0, 3'd4);  // drain in order
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'h22, 0, 3'd3);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'h33, 1, 3'd2);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'h44, 0, 3'd1);
        add(0, 0, 8'h00, 0, 0,   1,  0, 8'h00, 0, 3'd0);
        add(0, 1, 8'hA1, 0, 0,   1,  0, 8'h00, 0, 3'd0);  // refill
        add(0, 1, 8'hA2, 0, 0,   1,  1, 8'hA1, 0, 3'd1);
        add(0, 1, 8'hA3, 0, 0,   1,  1, 8'hA1, 0, 3'd2);
        add(0, 1, 8'hA4, 0, 0,   1,  1, 8'hA1, 0, 3'd3);
        add(0, 1, 8'hB0, 0, 1,   0,  1, 8'hA1, 0, 3'd4);  // full + pop + push attempt
        add(0, 0, 8'h00, 0, 0,   1,  1, 8'hA2, 0, 3'd3);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'hA2, 0, 3'd3);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'hA3, 0, 3'd2);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'hA4, 0, 3'd1);
        add(0, 1, 8'hA5, 0, 1,   1,  0, 8'h00, 0, 3'd0);  // empty: no bypass
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'hA5, 0, 3'd1);
        add(0, 0, 8'h00, 0, 0,   1,  0, 8'h00, 0, 3'd0);
        add(0, 1, 8'h01, 0, 0,   1,  0, 8'h00, 0, 3'd0);
        add(0, 1, 8'h02, 0, 0,   1,  1, 8'h01, 0, 3'd1);
        add(0, 1, 8'h03, 0, 0,   1,  1, 8'h01, 0, 3'd2);
        add(1, 0, 8'h00, 0, 0,   0,  0, 8'h00, 0, 3'd3);  // reset with 3 stored
        add(0, 1, 8'h7E, 0, 0,   1,  0, 8'h00, 0, 3'd0);
        add(0, 0, 8'h00, 0, 1,   1,  1, 8'h7E, 0, 3'd1);
        add(0, 0, 8'h00, 0, 0,   1,  0, 8'h00, 0, 3'd0);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            s_if.tvalid = vecs[i].sv; s_if.tdata = vecs[i].sd; s_if.tlast = vecs[i].sl;
            m_if.tready = vecs[i].mr;
            #1;
            chk($sformatf("v%0d.s_tready", i), 32'(s_if.tready), 32'(vecs[i].esr));
            chk($sformatf("v%0d.m_tvalid", i), 32'(m_if.tvalid), 32'(vecs[i].emv));
            chk($sformatf("v%0d.count", i),    32'(count),       32'(vecs[i].ecnt));
            if (vecs[i].emv) begin
                chk($sformatf("v%0d.m_tdata", i), 32'(m_if.tdata), 32'(vecs[i].emd));
                chk($sformatf("v%0d.m_tlast", i), 32'(m_if.tlast), 32'(vecs[i].eml));
            end
            step();
        end

        // Stream 0..255 with random stalls on both sides.
        lfsr = 16'hACE1;
        sent = 0; rcvd = 0; cyc = 0;
        rst = 1'b0;
        while (rcvd < 256 && cyc < 5000) begin
            s_if.tvalid = (sent < 256) && (lfsr[3:0] != 4'h0);
            s_if.tdata  = 8'(sent);
            s_if.tlast  = (sent % 8 == 7);
            m_if.tready = lfsr[0] ^ lfsr[5];
            #1;
            if (m_if.tvalid && m_if.tready) begin
                chk($sformatf("stream[%0d].data", rcvd), 32'(m_if.tdata), 32'(rcvd[7:0]));
                chk($sformatf("stream[%0d].last", rcvd), 32'(m_if.tlast), 32'(rcvd % 8 == 7));
                rcvd++;
            end
            if (s_if.tvalid && s_if.tready) sent++;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cyc++;
            step();
        end
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        #1;
        chk("stream.received", 32'(rcvd), 32'd256);
        chk("stream.final_count", 32'(count), 32'd0);
        chk("stream.final_valid", 32'(m_if.tvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
